axil_wr_regfile: RTL and testbench
==================================

# axil_wr_regfile

AXI-Lite write-only slave terminating one slave port of the AXI-Lite write interconnect (one instance per `s_axil_*` port). It accepts the write address (AW) and write data (W) channels independently, then commits byte-strobed data into a bank of memory-mapped control registers. It returns an OKAY or SLVERR response on the B channel and drives the register contents and per-register write strobes to fabric logic.

## Interface

- AXI_DATA_WIDTH, 32: data width; must be 32 or 64.
- AXI_ADDR_WIDTH, 32: address width.
- NUM_REGS, 16: number of registers, 1..256.
- BASE_ADDR, 32'h1000_0000: byte address of register 0; aligned to the register stride.
- RESET_VALUE, 0: reset value of every register, AXI_DATA_WIDTH bits.

Ports (all synchronous to `aclk`):

- aclk  in  1  clock.
- aresetn  in  1  one clock; reset is asynchronous and active-low.
- s_axil_awaddr  in  AXI_ADDR_WIDTH  write address.
- s_axil_awvalid  in  1  AW valid.
- s_axil_awready  out  1  AW ready.
- s_axil_wdata  in  AXI_DATA_WIDTH  write data.
- s_axil_wstrb  in  AXI_DATA_WIDTH/8  byte enables.
- s_axil_wvalid  in  1  W valid.
- s_axil_wready  out  1  W ready.
- s_axil_bresp  out  2  response: 2'b00 OKAY, 2'b10 SLVERR.
- s_axil_bvalid  out  1  B valid.
- s_axil_bready  in  1  B ready.
- reg_out  out  AXI_DATA_WIDTH x [NUM_REGS]  register contents (unpacked array).
- wr_pulse  out  NUM_REGS  one-cycle strobe per register on a committed write.

## Operation

- State: `aw_held` flag plus address holding register; `w_held` flag plus data/strobe holding registers; FSM states IDLE and RESP.
- `s_axil_awready = (state==IDLE) && !aw_held`. `s_axil_wready = (state==IDLE) && !w_held`. Both are combinational from registered state only, never from valid.
- AW handshake (valid && ready at an edge): latch awaddr and set aw_held. W handshake: latch wdata/wstrb and set w_held. Either may come first, or both may come in the same cycle.
- IDLE with aw_held && w_held: at the next edge, commit, go to RESP, set bvalid, clear both flags.
- Decode: `off = awaddr - BASE_ADDR` (AXI_ADDR_WIDTH bits, wrapping). Legal iff `awaddr >= BASE_ADDR` and `off < NUM_REGS*(AXI_DATA_WIDTH/8)`.
- Register index = `off / (AXI_DATA_WIDTH/8)`. Low address bits below the stride are ignored; unaligned addresses are accepted.
- Legal write: for each byte b with wstrb[b]=1, reg_out[idx] byte b takes wdata byte b. Other bytes are unchanged. `wr_pulse[idx]` is high for exactly the commit cycle +1 (the first RESP cycle). bresp = 2'b00.
- A legal write with wstrb=0 changes no data but still pulses wr_pulse and returns OKAY.
- Illegal write: no register change, no wr_pulse, bresp = 2'b10.
- RESP: hold bvalid and bresp stable until bready. On the B handshake edge, go to IDLE and clear bvalid.

## Timing

- Reset (aresetn low, asynchronous): state IDLE, flags clear, s_axil_bvalid 0, s_axil_bresp 2'b00, reg_out all RESET_VALUE, wr_pulse 0. awready and wready read 1 while reset is high after deassertion.
- Reset mid-transaction discards any held AW/W and any pending response; no partial register update is ever visible.
- Latency: last of the AW/W handshakes at edge E → commit and bvalid high from edge E+1. Registers read new values from E+1. wr_pulse is high in cycle E+1..E+2.
- bready already high at E+1: B handshake at edge E+2, readies high again from E+2. Throughput is one write per 3 cycles.
- awready/wready are low from the handshake of their own channel until the B handshake. A second AW is never accepted before the B handshake of the first write.
- bvalid never drops without bready; bresp never changes while bvalid is high.

## Test plan

- AW and W in the same cycle, awaddr 0x1000_0004, wdata 0xDEAD_BEEF, wstrb 4'hF, bready=1 → reg_out[1]=0xDEAD_BEEF, wr_pulse=16'h0002 for one cycle, bresp 00, bvalid exactly one cycle.
- W three cycles before AW (addr 0x1000_0000, wdata 0x1234_5678, wstrb 4'b0101) onto reg 0 = 0xFFFF_FFFF → reg_out[0]=0xFF34_FF78; wready low after the W handshake, awready stays high until AW.
- Out-of-range awaddr 0x1000_0040 (NUM_REGS=16) and below-base 0x0FFF_FFFC → bresp 2'b10, all registers unchanged, wr_pulse stays 0.
- bready held low 5 cycles after commit → bvalid/bresp stable 5 cycles; awready/wready low throughout, then high the cycle after the B handshake.
- aresetn pulsed low after AW accepted but before W → bvalid 0, reg_out all RESET_VALUE; a following complete write to 0x1000_003C succeeds with OKAY.
- Back-to-back writes to regs 2, 3, 2 with bready=1 → each commits in order, one wr_pulse per write, 3-cycle spacing, final reg_out[2] equals the third write.

Source files
------------

// File: rtl/axil_wr_regfile.sv
// AXI-Lite write-only slave committing byte-strobed writes into a bank of control registers.
// Latency: commit, bvalid and register update one cycle after the later of the AW/W handshakes.
// Backpressure: AW and W are each held until commit; no new AW/W accepted until the B handshake.
module axil_wr_regfile #(
  parameter int                          AXI_DATA_WIDTH = 32,
  parameter int                          AXI_ADDR_WIDTH = 32,
  parameter int                          NUM_REGS       = 16,
  parameter logic [AXI_ADDR_WIDTH-1:0]   BASE_ADDR      = 32'h1000_0000,
  parameter logic [AXI_DATA_WIDTH-1:0]   RESET_VALUE    = '0
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
  input  logic                          s_axil_awvalid,
  output logic                          s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
  input  logic                          s_axil_wvalid,
  output logic                          s_axil_wready,
  output logic [1:0]                    s_axil_bresp,
  output logic                          s_axil_bvalid,
  input  logic                          s_axil_bready,
  output logic [AXI_DATA_WIDTH-1:0]     reg_out [NUM_REGS],
  output logic [NUM_REGS-1:0]           wr_pulse
);

  localparam int STRB_W   = AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB = (AXI_DATA_WIDTH == 64) ? 3 : 2;
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] SPAN = AXI_ADDR_WIDTH'(NUM_REGS * STRB_W);

  typedef enum logic {IDLE, RESP} state_t;

  state_t                      state;
  state_t                      state_nxt;
  logic                        aw_held;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic                        w_held;
  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [STRB_W-1:0]           w_strb;
  logic [AXI_ADDR_WIDTH-1:0]   off;
  logic                        legal;
  logic [IDX_W-1:0]            idx;
  logic                        commit;
  logic                        aw_hs;
  logic                        w_hs;

  // Readies depend only on registered state so they never loop back through valid.
  assign s_axil_awready = (state == IDLE) && !aw_held;
  assign s_axil_wready  = (state == IDLE) && !w_held;
  assign s_axil_bvalid  = (state == RESP);

  assign aw_hs  = s_axil_awvalid && s_axil_awready;
  assign w_hs   = s_axil_wvalid && s_axil_wready;
  assign commit = (state == IDLE) && aw_held && w_held;

  // Address decode on the held address; the wrapping subtract is guarded by the >= test.
  assign off   = aw_addr - BASE_ADDR;
  assign legal = (aw_addr >= BASE_ADDR) && (off < SPAN);
  assign idx   = off[ADDR_LSB +: IDX_W];

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: commit moves to RESP, B handshake returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (commit) state_nxt = RESP;
      RESP:    if (s_axil_bready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Hold AW and W independently until both are present, then release them on commit.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held <= 1'b0;
      aw_addr <= '0;
      w_held  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_addr <= s_axil_awaddr;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= s_axil_wdata;
        w_strb <= s_axil_wstrb;
      end
    end
  end

  // Response code is captured at commit and stays frozen for the whole RESP state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)    s_axil_bresp <= 2'b00;
    else if (commit) s_axil_bresp <= legal ? 2'b00 : 2'b10;
  end

  // Register bank update and single-cycle write strobe on a legal commit.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) reg_out[i] <= RESET_VALUE;
    end else begin
      wr_pulse <= '0;
      if (commit && legal) begin
        wr_pulse[idx] <= 1'b1;
        for (int b = 0; b < STRB_W; b++) begin
          if (w_strb[b]) reg_out[idx][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_wr_regfile.sv
// Self-checking bench for axil_wr_regfile: directed scenarios plus randomized writes.
// Expected register contents come from an array model updated with plain byte arithmetic.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_axil_wr_regfile;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        aclk;
  logic        aresetn;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] reg_out [16];
  logic [15:0] wr_pulse;

  logic [31:0] model [16];
  int          n_assert = 0;
  int          n_fail   = 0;

  axil_wr_regfile dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_axil_awaddr  (awaddr),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .reg_out        (reg_out),
    .wr_pulse       (wr_pulse)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 16; i++) chk($sformatf("%s reg%0d", tag, i), reg_out[i], model[i]);
  endtask

  // One complete write. aw_dly/w_dly: cycles before each valid rises; b_dly: cycles bready
  // stays low once bvalid is seen. Returns the number of cycles until after the B handshake.
  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly, output int cycles);
    logic [1:0]  exp_resp;
    logic [15:0] exp_pulse;
    bit          legal;
    int          idx;
    bit          aw_done, w_done, aw_hs, w_hs, b_hs, got_b, seen_b;
    int          done_at, cyc, bcnt;
    chk_regs("pre");
    legal     = (addr >= BASE) && ((addr - BASE) < 32'd64);
    exp_resp  = legal ? 2'b00 : 2'b10;
    exp_pulse = '0;
    if (legal) begin
      idx = int'((addr - BASE) / 32'd4);
      exp_pulse[idx] = 1'b1;
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    end
    aw_done = 0; w_done = 0; got_b = 0; seen_b = 0;
    done_at = -1; cyc = 0; bcnt = 0;
    while (!got_b && cyc < 100) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      awaddr  = awvalid ? addr : $urandom;
      wvalid  = !w_done && (cyc >= w_dly);
      wdata   = wvalid ? data : $urandom;
      wstrb   = wvalid ? strb : 4'($urandom);
      aw_hs   = awvalid && awready;
      w_hs    = wvalid && wready;
      if (!aw_done) chk("awready open", awready, 1); else chk("awready blocked", awready, 0);
      if (!w_done)  chk("wready open", wready, 1);   else chk("wready blocked", wready, 0);
      b_hs = 0;
      if (bvalid) begin
        if (!seen_b) begin
          seen_b = 1;
          chk("b latency", cyc, done_at + 1);
          chk("wr_pulse commit", wr_pulse, exp_pulse);
          chk_regs("commit");
        end else begin
          chk("wr_pulse after commit", wr_pulse, 0);
        end
        chk("bresp", bresp, exp_resp);
        bready = (bcnt >= b_dly);
        b_hs   = bready;
        bcnt++;
      end else begin
        chk("wr_pulse before commit", wr_pulse, 0);
        bready = (b_dly == 0);
      end
      @(posedge aclk); #1;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done  = 1;
      if (aw_done && w_done && done_at < 0) done_at = cyc + 1;
      if (b_hs) got_b = 1;
      cyc++;
    end
    chk("B handshake within budget", got_b, 1);
    awvalid = 0; wvalid = 0; bready = 0;
    chk("bvalid after B", bvalid, 0);
    chk("awready after B", awready, 1);
    chk("wready after B", wready, 1);
    chk("wr_pulse after B", wr_pulse, 0);
    cycles = cyc;
  endtask

  initial begin
    int          cycles;
    logic [31:0] a;
    logic [31:0] w3;
    aresetn = 1'b0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("reset bvalid", bvalid, 0);
    chk("reset bresp", bresp, 2'b00);
    chk("reset wr_pulse", wr_pulse, 0);
    chk_regs("reset");
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("post-reset awready", awready, 1);
    chk("post-reset wready", wready, 1);

    // AW and W together, bready already high
    write_txn(32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, cycles);
    chk("t1 reg1 value", reg_out[1], 32'hDEAD_BEEF);
    chk("t1 three-cycle write", cycles, 3);

    // W three cycles ahead of AW, partial strobe
    write_txn(BASE, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, cycles);
    write_txn(BASE, 32'h1234_5678, 4'b0101, 3, 0, 0, cycles);
    chk("t2 reg0 merged", reg_out[0], 32'hFF34_FF78);

    // Out of range and below base
    write_txn(32'h1000_0040, 32'hA5A5_A5A5, 4'hF, 0, 0, 0, cycles);
    write_txn(32'h0FFF_FFFC, 32'h5A5A_5A5A, 4'hF, 0, 0, 0, cycles);

    // Legal write with no strobes: pulse and OKAY, no data change
    write_txn(32'h1000_0020, 32'hCAFE_F00D, 4'h0, 0, 0, 0, cycles);

    // bready held low five cycles
    write_txn(32'h1000_0008, 32'h0BAD_CAFE, 4'hF, 1, 0, 5, cycles);
    chk("t4 stall length", cycles, 9);

    // Reset after AW accepted, before W
    awaddr = 32'h1000_0004; awvalid = 1;
    chk("rst aw ready", awready, 1);
    @(posedge aclk); #1;
    awvalid = 0;
    chk("rst aw held", awready, 0);
    chk("rst w still open", wready, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("rst bvalid", bvalid, 0);
    chk("rst awready cleared", awready, 1);
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    chk_regs("mid reset");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("rst release bvalid", bvalid, 0);
    write_txn(32'h1000_003C, 32'h7777_8888, 4'hF, 0, 1, 0, cycles);
    chk("t5 reg15", reg_out[15], 32'h7777_8888);

    // Back-to-back writes to regs 2, 3, 2
    w3 = 32'h3333_CCCC;
    write_txn(32'h1000_0008, 32'h1111_2222, 4'hF, 0, 0, 0, cycles);
    chk("b2b first spacing", cycles, 3);
    write_txn(32'h1000_000C, 32'h4444_5555, 4'hF, 0, 0, 0, cycles);
    chk("b2b second spacing", cycles, 3);
    write_txn(32'h1000_0008, w3, 4'hF, 0, 0, 0, cycles);
    chk("b2b third spacing", cycles, 3);
    chk("b2b reg2 final", reg_out[2], w3);

    // Randomized writes against the model
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0:       a = BASE - 32'($urandom_range(1, 16));
        1:       a = BASE + 32'd64 + 32'($urandom_range(0, 64));
        default: a = BASE + 32'($urandom_range(0, 63));
      endcase
      write_txn(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), cycles);
    end
    chk_regs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
